// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, state encodings and default width for the calculator sequencer
package calc_pkg;

   localparam int CALC_WIDTH = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] ST_QI = 2'b00;
   localparam logic [1:0] ST_QC = 2'b01;
   localparam logic [1:0] ST_QD = 2'b10;

endpackage

// File: rtl/calc_iter_step.sv
// rtl/calc_iter_step.sv - one combinational step of the shared add/subtract/compare datapath
module calc_iter_step
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
)(
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   rem,
   input  logic [WIDTH-1:0]   count,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0]   rem_next,
   output logic [WIDTH-1:0]   count_next,
   output logic               finish,
   output logic               div_zero,
   output logic [WIDTH-1:0]   res_hi,
   output logic [WIDTH-1:0]   res_lo
);

   localparam logic [WIDTH-1:0] ONE = 1;

   logic [WIDTH:0] sum;
   assign sum = {1'b0, x} + {1'b0, y};

   // For div, count carries the running quotient; for mul it is the remaining multiplier
   always_comb begin
      acc_next   = acc;
      rem_next   = rem;
      count_next = count;
      finish     = 1'b0;
      div_zero   = 1'b0;
      res_hi     = '0;
      res_lo     = '0;
      case (op)
         OP_ADD: begin
            finish = 1'b1;
            res_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            res_lo = sum[WIDTH-1:0];
         end
         OP_SUB: begin
            finish = 1'b1;
            res_lo = x - y;
            res_hi = (x < y) ? '1 : '0;
         end
         OP_MUL: begin
            if (count == '0) begin
               finish           = 1'b1;
               {res_hi, res_lo} = acc;
            end else begin
               acc_next   = acc + {{WIDTH{1'b0}}, x};
               count_next = count - ONE;
            end
         end
         default: begin
            if (y == '0) begin
               finish   = 1'b1;
               div_zero = 1'b1;
            end else if (rem < y) begin
               finish = 1'b1;
               res_hi = count;
               res_lo = rem;
            end else begin
               rem_next   = rem - y;
               count_next = count + ONE;
            end
         end
      endcase
   end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - Start/Ack calculator sequencer (QI/QC/QD); CALC_CYCLE_COUNT_EN adds CycleCount
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
)(
   input  logic             board_clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Ack,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Xin,
   input  logic [WIDTH-1:0] Yin,
   output logic [WIDTH-1:0] ResultHi,
   output logic [WIDTH-1:0] ResultLo,
   output logic             Done,
   output logic             Err,
   output logic             Qi,
   output logic             Qc,
   output logic             Qd
`ifdef CALC_CYCLE_COUNT_EN
   ,
   output logic [15:0]      CycleCount
`endif
);

   logic [1:0]         state;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   x_r;
   logic [WIDTH-1:0]   y_r;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   cnt;

   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   cnt_next;
   logic               finish;
   logic               div_zero;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   calc_iter_step #(.WIDTH(WIDTH)) u_step (
      .op         (op_r),
      .x          (x_r),
      .y          (y_r),
      .acc        (acc),
      .rem        (rem),
      .count      (cnt),
      .acc_next   (acc_next),
      .rem_next   (rem_next),
      .count_next (cnt_next),
      .finish     (finish),
      .div_zero   (div_zero),
      .res_hi     (res_hi),
      .res_lo     (res_lo)
   );

   // Qi is derived from the other two so the indication stays one-hot for any state value
   assign Qc   = (state == ST_QC);
   assign Qd   = (state == ST_QD);
   assign Qi   = ~Qc & ~Qd;
   assign Done = Qd;

   // Handshake FSM plus operand, working and result registers
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state    <= ST_QI;
         op_r     <= OP_ADD;
         x_r      <= '0;
         y_r      <= '0;
         acc      <= '0;
         rem      <= '0;
         cnt      <= '0;
         ResultHi <= '0;
         ResultLo <= '0;
         Err      <= 1'b0;
      end else begin
         case (state)
            ST_QI: begin
               if (Start) begin
                  op_r     <= Op;
                  x_r      <= Xin;
                  y_r      <= Yin;
                  acc      <= '0;
                  rem      <= Xin;
                  cnt      <= (Op == OP_MUL) ? Yin : '0;
                  ResultHi <= '0;
                  ResultLo <= '0;
                  Err      <= 1'b0;
                  state    <= ST_QC;
               end
            end
            ST_QC: begin
               acc <= acc_next;
               rem <= rem_next;
               cnt <= cnt_next;
               if (finish) begin
                  ResultHi <= res_hi;
                  ResultLo <= res_lo;
                  Err      <= div_zero;
                  state    <= ST_QD;
               end
            end
            ST_QD: begin
               if (Ack) state <= ST_QI;
            end
            default: state <= ST_QI;
         endcase
      end
   end

`ifdef CALC_CYCLE_COUNT_EN
   // Counts QC cycles of the latest operation, saturating, held until the next Start
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset)
         CycleCount <= '0;
      else if (state == ST_QI && Start)
         CycleCount <= '0;
      else if (state == ST_QC && CycleCount != 16'hFFFF)
         CycleCount <= CycleCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
   import calc_pkg::*;

   logic       board_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Ack = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [7:0] Xin = 8'h00;
   logic [7:0] Yin = 8'h00;
   logic [7:0] ResultHi, ResultLo;
   logic       Done, Err, Qi, Qc, Qd;
`ifdef CALC_CYCLE_COUNT_EN
   logic [15:0] CycleCount;
`endif

   int checks = 0;
   int failures = 0;

   calc_sequencer #(.WIDTH(8)) dut (
      .board_clk (board_clk),
      .Reset     (Reset),
      .Start     (Start),
      .Ack       (Ack),
      .Op        (Op),
      .Xin       (Xin),
      .Yin       (Yin),
      .ResultHi  (ResultHi),
      .ResultLo  (ResultLo),
      .Done      (Done),
      .Err       (Err),
      .Qi        (Qi),
      .Qc        (Qc),
      .Qd        (Qd)
`ifdef CALC_CYCLE_COUNT_EN
      ,
      .CycleCount(CycleCount)
`endif
   );

   always #5 board_clk = ~board_clk;

   task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
      @(negedge board_clk);
      Xin = x; Yin = y; Op = op; Start = 1'b1;
      @(negedge board_clk);
      Start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!Done && cyc < 400) begin
         cyc++;
         @(negedge board_clk);
      end
   endtask

   task automatic ack_op();
      @(negedge board_clk);
      Ack = 1'b1;
      @(negedge board_clk);
      Ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge board_clk);
      checks++; if ({Qi, Qc, Qd} !== 3'b100) begin failures++; $display("FAIL reset_state: got %b expected 100", {Qi, Qc, Qd}); end
      checks++; if ({Done, Err} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {Done, Err}); end
      checks++; if ({ResultHi, ResultLo} !== 16'h0000) begin failures++; $display("FAIL reset_result: got %h expected 0000", {ResultHi, ResultLo}); end
      Reset = 1'b0;
   endtask

   task automatic test_add();
      int cyc;
      start_op(8'hFF, 8'h01, OP_ADD);
      wait_done(cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL add_cycles: got %0d expected 1", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'h0100) begin failures++; $display("FAIL add_result: got %h expected 0100", {ResultHi, ResultLo}); end
      checks++; if ({Done, Err, Qd} !== 3'b101) begin failures++; $display("FAIL add_flags: got %b expected 101", {Done, Err, Qd}); end
      ack_op();
   endtask

   task automatic test_sub();
      int cyc;
      start_op(8'h05, 8'h07, OP_SUB);
      wait_done(cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL sub_cycles: got %0d expected 1", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'hFFFE) begin failures++; $display("FAIL sub_result: got %h expected fffe", {ResultHi, ResultLo}); end
      ack_op();
      checks++; if ({Qi, Done} !== 2'b10) begin failures++; $display("FAIL sub_ack: got Qi,Done=%b expected 10", {Qi, Done}); end
   endtask

   task automatic test_mul();
      int cyc;
      start_op(8'h0F, 8'h11, OP_MUL);
      wait_done(cyc);
      checks++; if (cyc !== 18) begin failures++; $display("FAIL mul_cycles: got %0d expected 18", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'h00FF) begin failures++; $display("FAIL mul_result: got %h expected 00ff", {ResultHi, ResultLo}); end
      ack_op();
      start_op(8'hFF, 8'hFF, OP_MUL);
      wait_done(cyc);
      checks++; if (cyc !== 256) begin failures++; $display("FAIL mul_max_cycles: got %0d expected 256", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'hFE01) begin failures++; $display("FAIL mul_max_result: got %h expected fe01", {ResultHi, ResultLo}); end
`ifdef CALC_CYCLE_COUNT_EN
      checks++; if (CycleCount !== 16'd256) begin failures++; $display("FAIL mul_max_cyclecount: got %0d expected 256", CycleCount); end
`endif
      ack_op();
   endtask

   task automatic test_div();
      int cyc;
      start_op(8'd200, 8'd7, OP_DIV);
      wait_done(cyc);
      checks++; if (cyc !== 29) begin failures++; $display("FAIL div_cycles: got %0d expected 29", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'h1C04) begin failures++; $display("FAIL div_result: got %h expected 1c04", {ResultHi, ResultLo}); end
      ack_op();
      start_op(8'h10, 8'h00, OP_DIV);
      wait_done(cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL div0_cycles: got %0d expected 1", cyc); end
      checks++; if ({Err, ResultHi, ResultLo} !== 17'h10000) begin failures++; $display("FAIL div0_result: got err=%b res=%h expected err=1 res=0000", Err, {ResultHi, ResultLo}); end
      ack_op();
   endtask

   task automatic test_robust();
      int cyc;
      start_op(8'd200, 8'd7, OP_DIV);
      cyc = 0;
      while (!Done && cyc < 400) begin
         Xin = 8'($urandom);
         Yin = 8'($urandom);
         Op  = 2'($urandom);
         Ack = (cyc % 3 == 0);
         cyc++;
         @(negedge board_clk);
      end
      Ack = 1'b0;
      checks++; if (cyc !== 29) begin failures++; $display("FAIL robust_cycles: got %0d expected 29", cyc); end
      checks++; if ({Err, ResultHi, ResultLo} !== 17'h01C04) begin failures++; $display("FAIL robust_result: got err=%b res=%h expected err=0 res=1c04", Err, {ResultHi, ResultLo}); end
      ack_op();
   endtask

   task automatic test_start_held();
      @(negedge board_clk);
      Xin = 8'h01; Yin = 8'h02; Op = OP_ADD; Start = 1'b1;
      repeat (2) @(negedge board_clk);
      Xin = 8'h05; Yin = 8'h05;
      repeat (3) @(negedge board_clk);
      checks++; if ({Qd, ResultLo} !== 9'h103) begin failures++; $display("FAIL held_qd: got Qd=%b res=%h expected Qd=1 res=03", Qd, ResultLo); end
      Ack = 1'b1;
      @(negedge board_clk);
      Ack = 1'b0;
      checks++; if ({Qi, Done} !== 2'b10) begin failures++; $display("FAIL held_ack: got Qi,Done=%b expected 10", {Qi, Done}); end
      @(negedge board_clk);
      checks++; if (Qc !== 1'b1) begin failures++; $display("FAIL held_restart: got Qc=%b expected 1", Qc); end
      Start = 1'b0;
      @(negedge board_clk);
      checks++; if ({Qd, ResultHi, ResultLo} !== 17'h1000A) begin failures++; $display("FAIL held_result: got Qd=%b res=%h expected Qd=1 res=000a", Qd, {ResultHi, ResultLo}); end
      ack_op();
   endtask

   task automatic test_reset_mid();
      int cyc;
      start_op(8'hFF, 8'hFF, OP_MUL);
      repeat (99) @(negedge board_clk);
      #2;
      Reset = 1'b1;
      #1;
      checks++; if ({Qi, Qc, Qd, Done, Err} !== 5'b10000) begin failures++; $display("FAIL midreset_state: got %b expected 10000", {Qi, Qc, Qd, Done, Err}); end
      checks++; if ({ResultHi, ResultLo} !== 16'h0000) begin failures++; $display("FAIL midreset_result: got %h expected 0000", {ResultHi, ResultLo}); end
      @(negedge board_clk);
      Reset = 1'b0;
      start_op(8'h03, 8'h04, OP_MUL);
      wait_done(cyc);
      checks++; if (cyc !== 5) begin failures++; $display("FAIL after_reset_cycles: got %0d expected 5", cyc); end
      checks++; if ({ResultHi, ResultLo} !== 16'h000C) begin failures++; $display("FAIL after_reset_result: got %h expected 000c", {ResultHi, ResultLo}); end
`ifdef CALC_CYCLE_COUNT_EN
      checks++; if (CycleCount !== 16'd5) begin failures++; $display("FAIL after_reset_cyclecount: got %0d expected 5", CycleCount); end
`endif
      ack_op();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_robust();
      test_start_held();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
